disp_mux_bcd: RTL and testbench



---
 rtl/disp_mux_bcd_pkg.sv | 27 ++
 rtl/disp_mux_bcd_bcd_to_sseg.sv | 32 +++
 rtl/disp_mux_bcd.sv | 67 ++++++
 tb/tb_disp_mux_bcd.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/disp_mux_bcd_pkg.sv
// disp_mux_bcd_pkg: segment/anode constants shared by the display mux and its decoder.
// Segments are active-low in {g,f,e,d,c,b,a} order.
package disp_mux_bcd_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [3:0] AN_OFF   = 4'hF;
   localparam logic [7:0] SSEG_OFF = 8'hFF;

   typedef enum logic [1:0] {SEL_D0, SEL_D1, SEL_D2, SEL_D3} sel_e;

   function automatic logic [3:0] an_sel(input sel_e sel);
      return ~(4'b0001 << sel);
   endfunction

endpackage

// File: rtl/disp_mux_bcd_bcd_to_sseg.sv
// bcd_to_sseg: BCD digit to active-low 7-segment pattern; codes 10-15 show a dash.
// A set blank input overrides the digit with all segments off.
module bcd_to_sseg
   import disp_mux_bcd_pkg::*;
(
   input  logic [3:0] i_bcd,
   input  logic       i_blank,
   output logic [6:0] o_seg
);

   logic [6:0] w_dec;

   always_comb begin
      w_dec = SEG_DASH;
      case (i_bcd)
         4'd0: w_dec = SEG_0;
         4'd1: w_dec = SEG_1;
         4'd2: w_dec = SEG_2;
         4'd3: w_dec = SEG_3;
         4'd4: w_dec = SEG_4;
         4'd5: w_dec = SEG_5;
         4'd6: w_dec = SEG_6;
         4'd7: w_dec = SEG_7;
         4'd8: w_dec = SEG_8;
         4'd9: w_dec = SEG_9;
         default: w_dec = SEG_DASH;
      endcase
   end

   assign o_seg = i_blank ? SEG_BLANK : w_dec;

endmodule

// File: rtl/disp_mux_bcd.sv
// disp_mux_bcd: four-digit multiplexed common-anode display driver with freezable snapshot.
// Optional leading-zero blanking is enabled by defining LZB_EN.
module disp_mux_bcd
   import disp_mux_bcd_pkg::*;
#(
   parameter int N = 18
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] d3,
   input  logic [3:0] d2,
   input  logic [3:0] d1,
   input  logic [3:0] d0,
   input  logic [3:0] dp_in,
   input  logic       hold,
   output logic [3:0] an,
   output logic [7:0] sseg
);

   logic [N-1:0]    r_cnt;
   logic [3:0][3:0] r_snap;
   logic [3:0]      r_snap_dp;
   sel_e            w_sel;
   logic            w_blank;
   logic [6:0]      w_seg;

   assign w_sel = sel_e'(r_cnt[N-1 -: 2]);

`ifdef LZB_EN
   // w_lead[i]: every digit from i upward is zero with no dp, so digit i is a leading zero
   logic [3:0] w_lead;
   always_comb begin
      w_lead    = 4'b0000;
      w_lead[3] = (r_snap[3] == 4'd0) && !r_snap_dp[3];
      w_lead[2] = w_lead[3] && (r_snap[2] == 4'd0) && !r_snap_dp[2];
      w_lead[1] = w_lead[2] && (r_snap[1] == 4'd0) && !r_snap_dp[1];
   end
   assign w_blank = w_lead[w_sel];
`else
   assign w_blank = 1'b0;
`endif

   bcd_to_sseg u_dec (
      .i_bcd   (r_snap[w_sel]),
      .i_blank (w_blank),
      .o_seg   (w_seg)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt     <= '0;
         r_snap    <= '0;
         r_snap_dp <= '0;
         an        <= AN_OFF;
         sseg      <= SSEG_OFF;
      end else begin
         r_cnt <= r_cnt + 1'b1;
         if (!hold) begin
            r_snap    <= {d3, d2, d1, d0};
            r_snap_dp <= dp_in;
         end
         an   <= an_sel(w_sel);
         sseg <= {~r_snap_dp[w_sel], w_seg};
      end
   end

endmodule

// File: tb/tb_disp_mux_bcd.sv
// tb_disp_mux_bcd: randomized and directed checks of disp_mux_bcd (N=4) against a cycle-count model.
// Honours LZB_EN when the design is built with it.
module tb_disp_mux_bcd;

   localparam int N    = 4;
   localparam int P    = 2 ** (N - 2);
   localparam int FULL = 2 ** N;
   localparam logic [6:0] SEGT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic [3:0] d3 = '0, d2 = '0, d1 = '0, d0 = '0, dp_in = '0;
   logic       hold = 1'b0;
   logic [3:0] an;
   logic [7:0] sseg;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 0;

   int         m_cycle;
   int         m_snap [4];
   logic [3:0] m_dp;
   logic [3:0] exp_an = 4'hF;
   logic [7:0] exp_sseg = 8'hFF;

   always #5 clk = ~clk;

   disp_mux_bcd #(.N(N)) dut (
      .clk(clk), .reset_n(reset_n), .d3(d3), .d2(d2), .d1(d1), .d0(d0),
      .dp_in(dp_in), .hold(hold), .an(an), .sseg(sseg)
   );

   function automatic int m_sel();
      return (m_cycle % FULL) / P;
   endfunction

   function automatic logic [3:0] an_of(input int s);
      logic [3:0] a = 4'hF;
      a[s] = 1'b0;
      return a;
   endfunction

   function automatic bit m_blank(input int i);
      bit b = (i != 0);
`ifdef LZB_EN
      for (int j = i; j < 4; j++) if (m_snap[j] != 0 || m_dp[j]) b = 0;
`else
      b = 0;
`endif
      return b;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_cycle  <= 0;
         m_snap   <= '{default: 0};
         m_dp     <= '0;
         exp_an   <= 4'hF;
         exp_sseg <= 8'hFF;
      end else begin
         m_cycle  <= m_cycle + 1;
         exp_an   <= an_of(m_sel());
         exp_sseg <= {~m_dp[m_sel()], m_blank(m_sel()) ? 7'h7F : SEGT[m_snap[m_sel()]]};
         if (!hold) begin
            m_snap <= '{int'(d0), int'(d1), int'(d2), int'(d3)};
            m_dp   <= dp_in;
         end
      end
   end

   task automatic check(input string name, input logic [11:0] got, input logic [11:0] want,
                        input logic [11:0] mask);
      vectors++;
      if ((got & mask) !== (want & mask)) begin
         miscompares++;
         $display("FAIL %s: got an=%b sseg=%h, expected an=%b sseg=%h (mask %h)",
                  name, got[11:8], got[7:0], want[11:8], want[7:0], mask);
      end
   endtask

   always @(negedge clk) if (chk_en) check("model", {an, sseg}, {exp_an, exp_sseg}, 12'hFFF);

   task automatic wait_edges(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic rst_start(input logic [15:0] d, input logic [3:0] dp);
      @(negedge clk);
      {d3, d2, d1, d0} = d;
      dp_in   = dp;
      hold    = 1'b0;
      reset_n = 1'b0;
      #1;
      check("reset_off", {an, sseg}, 12'hFFF, 12'hFFF);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #1 reset_n = 1'b0;
      #1 chk_en = 1;

      rst_start(16'h1234, 4'b0000);
      wait_edges(1); check("first_edge", {an, sseg}, {4'b1110, 8'hC0}, 12'hFFF);
      wait_edges(1); check("digit0",     {an, sseg}, {4'b1110, 8'h99}, 12'hFFF);
      wait_edges(3); check("digit1",     {an, sseg}, {4'b1101, 8'hB0}, 12'hFFF);
      wait_edges(4); check("digit2",     {an, sseg}, {4'b1011, 8'hA4}, 12'hFFF);
      wait_edges(4); check("digit3",     {an, sseg}, {4'b0111, 8'hF9}, 12'hFFF);

      wait_edges(12); check("pre_reset_sel2", {an, sseg}, {4'b1011, 8'hA4}, 12'hFFF);
      #2 reset_n = 1'b0;
      #1 check("async_reset", {an, sseg}, 12'hFFF, 12'hFFF);
      @(negedge clk);
      reset_n = 1'b1;
      wait_edges(1); check("scan_restart", {an, sseg}, {4'b1110, 8'hC0}, 12'hFFF);

      for (int v = 0; v < 16; v++) begin
         {d3, d2, d1, d0} = {4{4'(v)}};
         dp_in = 4'b1000;
         wait_edges(2);
         check($sformatf("decode_%0d", v), {an, sseg}, {4'h0, 1'b0, SEGT[v]}, 12'h07F);
      end

      rst_start(16'h0005, 4'b0000);
      wait_edges(1);
      hold = 1'b1; d0 = 4'd8;
      wait_edges(1); check("hold_5", {an, sseg}, {4'b1110, 8'h92}, 12'hFFF);
      hold = 1'b0;
      wait_edges(1); check("hold_kept", {an, sseg}, {4'b1110, 8'h92}, 12'hFFF);
      wait_edges(1); check("hold_release", {an, sseg}, {4'b1110, 8'h80}, 12'hFFF);

      rst_start(16'h0007, 4'b0010);
      wait_edges(2); check("dp_d0", {an, sseg}, {4'b1110, 8'hF8}, 12'hFFF);
      wait_edges(4); check("dp_d1", {an, sseg}, {4'b1101, 8'h40}, 12'hFFF);
`ifdef LZB_EN
      wait_edges(4); check("dp_d2", {an, sseg}, {4'b1011, 8'hFF}, 12'hFFF);
      wait_edges(4); check("dp_d3", {an, sseg}, {4'b0111, 8'hFF}, 12'hFFF);
      rst_start(16'h0007, 4'b0000);
      wait_edges(2); check("lzb_d0", {an, sseg}, {4'b1110, 8'hF8}, 12'hFFF);
      wait_edges(4); check("lzb_d1", {an, sseg}, {4'b1101, 8'hFF}, 12'hFFF);
      wait_edges(4); check("lzb_d2", {an, sseg}, {4'b1011, 8'hFF}, 12'hFFF);
      wait_edges(4); check("lzb_d3", {an, sseg}, {4'b0111, 8'hFF}, 12'hFFF);
`else
      wait_edges(4); check("dp_d2", {an, sseg}, {4'b1011, 8'hC0}, 12'hFFF);
      wait_edges(4); check("dp_d3", {an, sseg}, {4'b0111, 8'hC0}, 12'hFFF);
`endif

      for (int c = 0; c < 800; c++) begin
         d3    = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         d2    = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         d1    = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         d0    = 4'($urandom_range(0, 15));
         dp_in = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
         hold  = ($urandom_range(0, 3) == 0);
         wait_edges($urandom_range(1, 3));
      end

      wait_edges(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
